hs4_rx: RTL and testbench
=========================

Name: hs4_rx

Overview:
- Destination-side responder of a four-phase req/ack bundled-data handshake.
- The initiator lives in a foreign clock domain. It holds data_in stable while req is high, and drops req only after it sees ack.
- This block synchronizes req into clk, captures the word and presents it on a local valid/ready port. It returns ack only after the local consumer accepts the word.
- It sits at the receiving edge of every multi-bit clock-domain crossing, paired with the pulse/level synchronizers.

Parameters:
- DATA_W, 8, width of the data_in and out_data buses.
- SYNC_STAGES, 2, flops in the req synchronizer chain; legal values are 2 or more.
- CNT_W, 16, width of the transfer counter.

Ports:
- clk  in  1  single block clock (destination domain).
- rst  in  1  synchronous reset, active-high.
- req_in  in  1  asynchronous request from the initiator.
- data_in  in  DATA_W  bundled data; stable from req_in rise until ack_out rise.
- ack_out  out  1  acknowledge to the initiator; registered.
- out_valid  out  1  captured word available; registered.
- out_ready  in  1  consumer accepts the word.
- out_data  out  DATA_W  captured word; registered.
- err  out  1  sticky protocol-violation flag.
- err_clr  in  1  clears err.
- busy  out  1  high when the state is not IDLE.
- xfer_cnt  out  CNT_W  count of completed local handshakes.

Behaviour:
- Clocking and reset:
  - One clock. Reset is synchronous and active-high: clk, rst.
  - Reset clears the sync chain, sets state to IDLE, and drives ack_out, out_valid, err, busy = 0, out_data = 0, xfer_cnt = 0.
- Synchronizer: req_sync = sync[SYNC_STAGES-1]. A req_in rise sampled at edge 1 gives req_sync = 1 after edge SYNC_STAGES.
- State IDLE (ack_out = 0, out_valid = 0):
  - If req_sync = 1: capture out_data <= data_in, go to VALID.
  - out_valid rises after edge SYNC_STAGES+1.
- State VALID (out_valid = 1, out_data held constant):
  - out_ready = 1 and req_sync = 1: xfer_cnt += 1, go to ACK. ack_out = 1 and out_valid = 0 after the same edge.
  - out_ready = 0 and req_sync = 0 (early req drop): set err, go to IDLE, out_valid = 0. No ack, no count, word discarded.
  - out_ready = 1 and req_sync = 0 together: the handshake wins. Count, set err, go to ACK.
  - Otherwise hold.
- State ACK (ack_out = 1):
  - If req_sync = 0: go to IDLE, ack_out = 0 after that edge.
  - A new capture needs req_sync seen high again from IDLE, so one req phase yields exactly one word.
- Latency:
  - req_in rise to out_valid: SYNC_STAGES+1 edges.
  - Accept to ack_out rise: 1 edge.
  - req_in fall to ack_out fall: SYNC_STAGES+1 edges.
- err: set on any violation; cleared by err_clr when no set occurs in the same cycle. Set wins over clear.
- xfer_cnt wraps modulo 2^CNT_W.
- busy = (state != IDLE).
- Reset mid-transfer:
  - ack_out drops immediately.
  - A req_in still high after reset release is captured again as a new word. Duplicate suppression is a system-level responsibility.
- Only req_in is synchronized. data_in is sampled solely in the IDLE-to-VALID edge.

Test Plan:
- Single transfer: SYNC_STAGES = 2, req_in rise with data_in = 0xA5, out_ready held 1 -> out_valid high after 3 edges with out_data = 0xA5. Accepted on the first VALID cycle; ack_out high on the next edge. req_in low -> ack_out low 3 edges later; xfer_cnt = 1.
- Backpressure: out_ready = 0 for 10 cycles with data_in = 0x3C -> out_valid and out_data = 0x3C stable all 10 cycles, ack_out = 0. Then out_ready = 1 -> ack_out = 1 after 1 edge.
- Early req drop in VALID with out_ready = 0 -> err = 1, out_valid = 0, ack_out never rises, xfer_cnt unchanged. err_clr pulse -> err = 0. err_clr in the same cycle as a new violation -> err stays 1.
- Back-to-back: 4 words (0x01, 0x02, 0x03, 0x04), initiator reacting to ack -> exactly 4 out_valid/out_ready handshakes, in order, no duplicates; xfer_cnt = 4.
- Wrap: CNT_W = 4, 17 transfers -> xfer_cnt = 1.
- Reset mid-transfer: rst asserted in VALID state -> next edge all outputs at reset values. Release with req_in still high -> word recaptured, out_valid after SYNC_STAGES+1 edges.

Source files
------------

// File: rtl/hs4_rx.sv
// hs4_rx: four-phase req/ack responder that synchronizes req, captures data and hands it to a valid/ready consumer.
module hs4_rx #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              ack_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              err,
  input  logic              err_clr,
  output logic              busy,
  output logic [CNT_W-1:0]  xfer_cnt
);
  typedef enum logic [1:0] {IDLE, VALID, ACK} state_t;
  state_t                 state;
  logic [SYNC_STAGES-1:0] sync;
  logic                   req_sync, err_set;
  assign req_sync = sync[SYNC_STAGES-1];
  // any req drop while a word is still unaccepted is a violation, even if accepted now
  assign err_set  = (state == VALID) && !req_sync;
  always_ff @(posedge clk) begin
    if (rst) begin
      sync      <= '0;
      state     <= IDLE;
      ack_out   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      err       <= 1'b0;
      busy      <= 1'b0;
      xfer_cnt  <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], req_in};
      err  <= err_set | (err & ~err_clr);
      case (state)
        IDLE: if (req_sync) begin
          out_data  <= data_in;
          out_valid <= 1'b1;
          busy      <= 1'b1;
          state     <= VALID;
        end
        VALID: if (out_ready) begin
          xfer_cnt  <= xfer_cnt + CNT_W'(1);
          out_valid <= 1'b0;
          ack_out   <= 1'b1;
          state     <= ACK;
        end else if (!req_sync) begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        ACK: if (!req_sync) begin
          ack_out <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hs4_rx.sv
// tb_hs4_rx: transaction-level initiator/consumer bench with latency, data-order, error and counter-wrap checks.
module tb_hs4_rx;
  localparam int DW = 8, SS = 2, CW = 4, LAT = SS + 1;
  logic clk = 0, rst = 1, req_in = 0, out_ready = 0, err_clr = 0;
  logic [DW-1:0] data_in = 0, out_data;
  logic ack_out, out_valid, err, busy;
  logic [CW-1:0] xfer_cnt;
  int n_cmp = 0, n_bad = 0, exp_cnt = 0;
  hs4_rx #(.DATA_W(DW), .SYNC_STAGES(SS), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .req_in(req_in), .data_in(data_in), .ack_out(ack_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .err(err),
    .err_clr(err_clr), .busy(busy), .xfer_cnt(xfer_cnt)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic wait_valid(input logic [DW-1:0] d);
    int n = 0;
    do begin @(negedge clk); n++; end while (!out_valid && n < 20);
    check("rise_lat", n, LAT);
    check("cap_data", out_data, d);
    check("busy_valid", busy, 1);
  endtask
  task automatic xfer(input logic [DW-1:0] d, input int hold);
    int n = 0;
    @(negedge clk); data_in = d; req_in = 1;
    wait_valid(d);
    repeat (hold) begin
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_data", out_data, d);
      check("hold_ack", ack_out, 0);
    end
    out_ready = 1;
    @(negedge clk); out_ready = 0;
    exp_cnt = (exp_cnt + 1) % (1 << CW);
    check("ack_rise", ack_out, 1);
    check("valid_drop", out_valid, 0);
    check("cnt", xfer_cnt, exp_cnt);
    req_in = 0; data_in = DW'($urandom);
    do begin @(negedge clk); n++; end while (ack_out && n < 20);
    check("fall_lat", n, LAT);
    check("busy_idle", busy, 0);
  endtask
  // req dropped while word unaccepted; mode 0 plain, 1 with err_clr colliding, 2 with accept colliding
  task automatic drop(input logic [DW-1:0] d, input int mode);
    @(negedge clk); data_in = d; req_in = 1;
    wait_valid(d);
    req_in = 0;
    repeat (SS) @(negedge clk);
    check("drop_still_valid", out_valid, 1);
    err_clr = (mode == 1);
    out_ready = (mode == 2);
    @(negedge clk); err_clr = 0; out_ready = 0;
    if (mode == 2) exp_cnt = (exp_cnt + 1) % (1 << CW);
    check("drop_err", err, 1);
    check("drop_valid", out_valid, 0);
    check("drop_ack", ack_out, mode == 2);
    check("drop_cnt", xfer_cnt, exp_cnt);
    @(negedge clk);
    check("drop_ack_after", ack_out, 0);
    check("drop_busy", busy, 0);
  endtask
  task automatic reset_vals(input string tag);
    check({tag, "_ack"}, ack_out, 0);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_data"}, out_data, 0);
    check({tag, "_cnt"}, xfer_cnt, 0);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    reset_vals("rst");
    rst = 0;
    xfer(8'hA5, 0);
    xfer(8'h3C, 10);
    drop(8'h77, 0);
    @(negedge clk); err_clr = 1;
    @(negedge clk); err_clr = 0;
    check("err_clr", err, 0);
    drop(8'h55, 1);
    @(negedge clk); err_clr = 1;
    @(negedge clk); err_clr = 0;
    check("err_clr2", err, 0);
    drop(8'h99, 2);
    for (int i = 1; i <= 4; i++) xfer(DW'(i), 0);
    check("b2b_cnt", xfer_cnt, 7);
    // reset while a word is presented, req kept high across it
    @(negedge clk); data_in = 8'hC3; req_in = 1;
    wait_valid(8'hC3);
    rst = 1;
    @(negedge clk);
    reset_vals("mid_rst");
    rst = 0; exp_cnt = 0;
    wait_valid(8'hC3);
    out_ready = 1;
    @(negedge clk); out_ready = 0; req_in = 0;
    exp_cnt = 1;
    check("recap_ack", ack_out, 1);
    check("recap_cnt", xfer_cnt, 1);
    repeat (LAT) @(negedge clk);
    check("recap_ack_fall", ack_out, 0);
    for (int i = 0; i < 16; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      xfer(DW'($urandom), $urandom_range(0, 4));
    end
    check("wrap_cnt", xfer_cnt, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
